rd_buf_sched: RTL and testbench

Read-burst scheduler that fills the 256-bit write side of the frame read buffer (prefetch FIFO, 512 × 256 b) from the DDR read channel. On a frame request it splits the frame into fixed-length read bursts and issues them on an AXI-style AR channel. It streams the returned R beats into the buffer. Credit-based flow control guarantees the buffer never overflows. The block sits entirely in the DDR/buffer write clock domain, between the frame-timing logic and the buffer.

---
 rtl/rd_buf_sched_pkg.sv | 24 ++
 rtl/rd_buf_credit_cnt.sv | 42 ++++
 rtl/rd_buf_sched.sv | 172 +++++++++++++++++
 tb/tb_rd_buf_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_buf_sched_pkg.sv
// Shared types and sizing helpers for the read-burst scheduler.
package rd_buf_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Byte distance between consecutive burst start addresses.
    function automatic int burst_stride(input int burst_len, input int data_w);
        return burst_len * data_w / 8;
    endfunction

    // One extra bit so the counter can hold the full depth value.
    function automatic int credit_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int outst_w(input int max_outst);
        return $clog2(max_outst + 1);
    endfunction

endpackage

// File: rtl/rd_buf_credit_cnt.sv
// Saturating buffer-credit counter: +1 per returned word, -amt per issued burst.
module rd_buf_credit_cnt
    import rd_buf_sched_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ret,
    input  logic             i_take,
    input  logic [AMT_W-1:0] i_amt,
    output logic             o_credit_ok
);

    localparam int CW = credit_w(DEPTH);
    localparam int SW = CW + 1;

    logic [CW-1:0] r_credits;
    logic [SW-1:0] w_credits_next;

    // i_take is only ever asserted while credits >= i_amt, so no underflow.
    always_comb begin
        w_credits_next = {1'b0, r_credits} + SW'(i_ret);
        if (i_take) begin
            w_credits_next = w_credits_next - SW'(i_amt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= CW'(DEPTH);
        end else if (w_credits_next > SW'(DEPTH)) begin
            r_credits <= CW'(DEPTH);
        end else begin
            r_credits <= w_credits_next[CW-1:0];
        end
    end

    assign o_credit_ok = (r_credits >= CW'(i_amt));

endmodule

// File: rtl/rd_buf_sched.sv
// Splits a frame into fixed-length AR bursts under credit/outstanding limits and streams R beats into the buffer.
// Optional RD_BUF_SCHED_ERR_CHK_EN builds a per-burst r_last checker driving the sticky err flag.
module rd_buf_sched
    import rd_buf_sched_pkg::*;
#(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 256,
    parameter int LEN_W     = 20,
    parameter int BURST_LEN = 16,
    parameter int BUF_DEPTH = 512,
    parameter int MAX_OUTST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [LEN_W-1:0]  frame_beats,
    output logic              busy,
    output logic              done,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [7:0]        ar_len,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DATA_W-1:0] r_data,
    input  logic              r_last,
    output logic              buf_wr_en,
    output logic [DATA_W-1:0] buf_wr_data,
    input  logic              buf_wr_rdy,
    input  logic              credit_ret,
    output logic              err
);

    localparam int                BLEN_W = $clog2(BURST_LEN + 1);
    localparam int                OW     = outst_w(MAX_OUTST);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(burst_stride(BURST_LEN, DATA_W));

    state_t             r_state, w_state_next;
    logic [ADDR_W-1:0]  r_addr, w_addr_next;
    logic [LEN_W-1:0]   r_rem_req, w_rem_req_next;
    logic [LEN_W-1:0]   r_rem_rcv, w_rem_rcv_next;
    logic [OW-1:0]      r_outst, w_outst_next;
    logic               r_done, w_done_next;
    logic [BLEN_W-1:0]  w_blen;
    logic               w_credit_ok;
    logic               w_ar_hs;
    logic               w_beat_acc;
    logic               w_last_acc;

    assign w_blen = (r_rem_req >= LEN_W'(BURST_LEN)) ? BLEN_W'(BURST_LEN) : r_rem_req[BLEN_W-1:0];

    // AR outputs derive only from registers; credits and outstanding can only
    // improve while waiting, so the request holds steady until ar_ready.
    assign ar_valid = (r_state == REQ) && w_credit_ok && (r_outst < OW'(MAX_OUTST));
    assign ar_addr  = r_addr;
    assign ar_len   = (r_state == REQ) ? 8'(w_blen - 1'b1) : 8'd0;
    assign w_ar_hs  = ar_valid & ar_ready;

    assign r_ready     = buf_wr_rdy;
    assign buf_wr_en   = r_valid & buf_wr_rdy;
    assign buf_wr_data = r_data;
    assign w_beat_acc  = r_valid & buf_wr_rdy;
    assign w_last_acc  = w_beat_acc & r_last;

    assign busy = (r_state != IDLE);
    assign done = r_done;

    rd_buf_credit_cnt #(
        .DEPTH (BUF_DEPTH),
        .AMT_W (BLEN_W)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .i_ret       (credit_ret),
        .i_take      (w_ar_hs),
        .i_amt       (w_blen),
        .o_credit_ok (w_credit_ok)
    );

    always_comb begin
        w_state_next   = r_state;
        w_addr_next    = r_addr;
        w_rem_req_next = r_rem_req;
        w_rem_rcv_next = r_rem_rcv;
        w_done_next    = 1'b0;
        w_outst_next   = r_outst + OW'(w_ar_hs) - OW'(w_last_acc && (r_outst != '0));

        case (r_state)
            IDLE: begin
                if (frame_start) begin
                    w_addr_next    = frame_base;
                    w_rem_req_next = frame_beats;
                    w_rem_rcv_next = frame_beats;
                    if (frame_beats == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (w_ar_hs) begin
                    w_addr_next    = r_addr + STRIDE;
                    w_rem_req_next = r_rem_req - LEN_W'(w_blen);
                    if (r_rem_req == LEN_W'(w_blen)) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
            end
            default: w_state_next = IDLE;
        endcase

        if ((r_state != IDLE) && w_beat_acc && (r_rem_rcv != '0)) begin
            w_rem_rcv_next = r_rem_rcv - 1'b1;
            if (r_rem_rcv == LEN_W'(1)) begin
                w_state_next = IDLE;
                w_done_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_rem_req <= '0;
            r_rem_rcv <= '0;
            r_outst   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_addr    <= w_addr_next;
            r_rem_req <= w_rem_req_next;
            r_rem_rcv <= w_rem_rcv_next;
            r_outst   <= w_outst_next;
            r_done    <= w_done_next;
        end
    end

`ifdef RD_BUF_SCHED_ERR_CHK_EN
    logic [BLEN_W-1:0] r_beat_cnt;
    logic              r_err;
    logic              w_exp_last;
    logic              w_bad_beat;

    // A burst ends on a full BURST_LEN or on the frame's final beat.
    assign w_exp_last = (r_beat_cnt == BLEN_W'(BURST_LEN - 1)) || (r_rem_rcv == LEN_W'(1));
    assign w_bad_beat = w_beat_acc & ((r_last ^ w_exp_last) | (r_outst == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_beat_acc) begin
                r_beat_cnt <= (r_last || w_exp_last) ? '0 : r_beat_cnt + 1'b1;
            end
            if (w_bad_beat) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rd_buf_sched.sv
// Randomized bench for rd_buf_sched: AXI read slave, buffer-side knobs and a frame-level reference model.
module tb_rd_buf_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame_start;
    logic [27:0]  frame_base;
    logic [19:0]  frame_beats;
    logic         busy, done, ar_valid, ar_ready;
    logic [27:0]  ar_addr;
    logic [7:0]   ar_len;
    logic         r_valid, r_ready, r_last;
    logic [255:0] r_data;
    logic         buf_wr_en, buf_wr_rdy, credit_ret, err;
    logic [255:0] buf_wr_data;

    always #5 clk = ~clk;

    rd_buf_sched dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_base(frame_base),
        .frame_beats(frame_beats), .busy(busy), .done(done), .ar_valid(ar_valid),
        .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len), .r_valid(r_valid),
        .r_ready(r_ready), .r_data(r_data), .r_last(r_last), .buf_wr_en(buf_wr_en),
        .buf_wr_data(buf_wr_data), .buf_wr_rdy(buf_wr_rdy), .credit_ret(credit_ret), .err(err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus knobs (percent probability per cycle)
    int ar_rdy_pct, r_pct, wr_rdy_pct, cr_pct;
    int early_last_at = -1;

    // Reference model: frame described by base/beats, bursts indexed 0..n_ar-1
    bit          m_busy, m_done;
    int          m_credits, m_outst, m_idx, m_n_ar, m_rcv_left, m_beats;
    logic [27:0] m_base;

    // Observations
    logic [27:0] ar_addr_q[$];
    int          ar_len_q[$];
    int          n_wr, n_done, n_valid_dev, n_ar_dev, n_dp_dev, n_ctl_dev, n_err_seen;

    // Read slave
    int sl_q[$];
    int sl_beat;

    function automatic int m_blen(input int idx);
        int rem;
        rem = m_beats - 16 * idx;
        return (rem > 16) ? 16 : rem;
    endfunction

    function automatic bit exp_valid();
        return m_busy && (m_idx < m_n_ar) && (m_credits >= m_blen(m_idx)) && (m_outst < 4);
    endfunction

    task automatic clear_obs();
        ar_addr_q.delete();
        ar_len_q.delete();
        n_wr = 0; n_done = 0; n_valid_dev = 0; n_ar_dev = 0;
        n_dp_dev = 0; n_ctl_dev = 0; n_err_seen = 0;
    endtask

    task automatic reset_model();
        m_busy = 0; m_done = 0; m_credits = 512; m_outst = 0;
        m_idx = 0; m_n_ar = 0; m_rcv_left = 0; m_beats = 0; m_base = '0;
        sl_q.delete();
        sl_beat = 0;
        clear_obs();
    endtask

    // One clock cycle: drive, observe at posedge+2, advance model at posedge. Returns at posedge+1.
    task automatic step();
        bit ev, hs_m, acc, old_busy;
        int bl;
        ar_ready   = ($urandom_range(99) < ar_rdy_pct);
        buf_wr_rdy = ($urandom_range(99) < wr_rdy_pct);
        credit_ret = ($urandom_range(99) < cr_pct);
        for (int k = 0; k < 8; k++) r_data[k*32 +: 32] = $urandom;
        if (sl_q.size() > 0 && $urandom_range(99) < r_pct) begin
            r_valid = 1'b1;
            r_last  = (sl_beat == sl_q[0] - 1) || (sl_beat == early_last_at);
        end else begin
            r_valid = 1'b0;
            r_last  = 1'b0;
        end
        #1;
        ev = exp_valid();
        if (ar_valid !== ev) n_valid_dev++;
        if (ev && (ar_addr !== m_base + 28'(512 * m_idx) || ar_len !== 8'(m_blen(m_idx) - 1))) n_ar_dev++;
        if (r_ready !== buf_wr_rdy || buf_wr_en !== (r_valid & buf_wr_rdy) ||
            (buf_wr_en === 1'b1 && buf_wr_data !== r_data)) n_dp_dev++;
        if (done !== m_done || busy !== m_busy) n_ctl_dev++;
        if (err !== 1'b0) n_err_seen++;
        if (done === 1'b1) n_done++;
        if (buf_wr_en === 1'b1) n_wr++;
        if (ar_valid === 1'b1 && ar_ready) begin
            ar_addr_q.push_back(ar_addr);
            ar_len_q.push_back(int'(ar_len));
            sl_q.push_back(int'(ar_len) + 1);
        end
        @(posedge clk);
        hs_m = ev && ar_ready;
        acc  = r_valid && buf_wr_rdy;
        bl   = m_blen(m_idx);
        old_busy = m_busy;
        m_credits = m_credits + int'(credit_ret) - (hs_m ? bl : 0);
        if (m_credits > 512) m_credits = 512;
        m_outst = m_outst + int'(hs_m) - ((acc && r_last && m_outst > 0) ? 1 : 0);
        if (hs_m) m_idx++;
        m_done = 0;
        if (old_busy) begin
            if (acc && m_rcv_left > 0) begin
                m_rcv_left--;
                if (m_rcv_left == 0) begin m_busy = 0; m_done = 1; end
            end
        end else if (frame_start) begin
            if (frame_beats == 0) m_done = 1;
            else begin
                m_busy = 1; m_base = frame_base; m_beats = int'(frame_beats);
                m_n_ar = (m_beats + 15) / 16; m_idx = 0; m_rcv_left = m_beats;
            end
        end
        if (acc) begin
            if (r_last) begin void'(sl_q.pop_front()); sl_beat = 0; end
            else sl_beat++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_start = 0; r_valid = 0; r_last = 0;
        ar_ready = 0; credit_ret = 0; buf_wr_rdy = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
    endtask

    task automatic start_frame(input logic [27:0] base, input int beats);
        frame_start = 1'b1; frame_base = base; frame_beats = 20'(beats);
        step();
        frame_start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, output bit ok);
        int d0;
        d0 = n_done;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (n_done > d0) begin ok = 1; return; end
        end
    endtask

    task automatic set_knobs(input int a, input int r, input int w, input int c);
        ar_rdy_pct = a; r_pct = r; wr_rdy_pct = w; cr_pct = c;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if ({busy, done, ar_valid, buf_wr_en, err} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {busy, done, ar_valid, buf_wr_en, err}); else n_pass++;
        n_checks++; if (ar_addr !== 28'h0 || ar_len !== 8'h0) $display("FAIL reset_ar: got addr=%h len=%0d want 0/0", ar_addr, ar_len); else n_pass++;
        n_checks++; if (dut.u_credit.r_credits !== 10'd512) $display("FAIL reset_credits: got %0d want 512", dut.u_credit.r_credits); else n_pass++;
        rst = 1'b0;
        reset_model();
    endtask

    task automatic test_basic_split();
        bit ok;
        logic [27:0] exp_a[3];
        int exp_l[3];
        exp_a[0] = 28'h100000; exp_a[1] = 28'h100200; exp_a[2] = 28'h100400;
        exp_l[0] = 15; exp_l[1] = 15; exp_l[2] = 7;
        do_reset();
        set_knobs(70, 70, 80, 50);
        start_frame(28'h100000, 40);
        run_until_done(600, ok);
        $display("basic frame base=100000 beats=40 ars=%0d writes=%0d", ar_addr_q.size(), n_wr);
        n_checks++; if (ok !== 1'b1) $display("FAIL basic_done: timed out, got %0d want 1", ok); else n_pass++;
        n_checks++; if (ar_addr_q.size() !== 3) $display("FAIL basic_ar_count: got %0d want 3", ar_addr_q.size()); else n_pass++;
        for (int i = 0; i < 3 && i < ar_addr_q.size(); i++) begin
            n_checks++; if (ar_addr_q[i] !== exp_a[i] || ar_len_q[i] !== exp_l[i]) $display("FAIL basic_ar%0d: got %h/%0d want %h/%0d", i, ar_addr_q[i], ar_len_q[i], exp_a[i], exp_l[i]); else n_pass++;
        end
        n_checks++; if (n_wr !== 40) $display("FAIL basic_writes: got %0d want 40", n_wr); else n_pass++;
        n_checks++; if (n_valid_dev + n_ar_dev + n_dp_dev + n_ctl_dev + n_err_seen !== 0) $display("FAIL basic_model: dev valid=%0d ar=%0d dp=%0d ctl=%0d err=%0d want all 0", n_valid_dev, n_ar_dev, n_dp_dev, n_ctl_dev, n_err_seen); else n_pass++;
    endtask

    task automatic test_random_frames();
        bit ok;
        int beats;
        int fixed[4];
        logic [27:0] base;
        fixed[0] = 1; fixed[1] = 15; fixed[2] = 16; fixed[3] = 17;
        do_reset();
        for (int f = 0; f < 8; f++) begin
            set_knobs($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(20, 100));
            beats = (f < 4) ? fixed[f] : $urandom_range(1, 120);
            base  = {19'($urandom_range(0, 524287)), 9'b0};
            clear_obs();
            start_frame(base, beats);
            run_until_done(5000, ok);
            $display("random frame %0d base=%h beats=%0d ars=%0d writes=%0d", f, base, beats, ar_addr_q.size(), n_wr);
            n_checks++; if (ok !== 1'b1 || n_wr !== beats) $display("FAIL rand%0d_writes: got done=%0d wr=%0d want 1/%0d", f, ok, n_wr, beats); else n_pass++;
            n_checks++; if (ar_addr_q.size() !== (beats + 15) / 16) $display("FAIL rand%0d_ars: got %0d want %0d", f, ar_addr_q.size(), (beats + 15) / 16); else n_pass++;
            n_checks++; if (n_valid_dev + n_ar_dev + n_dp_dev + n_ctl_dev + n_err_seen !== 0) $display("FAIL rand%0d_model: dev valid=%0d ar=%0d dp=%0d ctl=%0d err=%0d want all 0", f, n_valid_dev, n_ar_dev, n_dp_dev, n_ctl_dev, n_err_seen); else n_pass++;
        end
    endtask

    task automatic test_credit_starvation();
        bit ok;
        do_reset();
        set_knobs(100, 100, 100, 0);
        start_frame(28'h0, 1024);
        repeat (700) step();
        $display("starve frame beats=1024 ars_before_credit=%0d", ar_addr_q.size());
        n_checks++; if (ar_addr_q.size() !== 32 || ar_valid !== 1'b0) $display("FAIL starve_32: got ars=%0d valid=%b want 32/0", ar_addr_q.size(), ar_valid); else n_pass++;
        cr_pct = 100;
        repeat (15) step();
        cr_pct = 0;
        n_checks++; if (ar_addr_q.size() !== 32 || ar_valid !== 1'b0) $display("FAIL starve_15cr: got ars=%0d valid=%b want 32/0", ar_addr_q.size(), ar_valid); else n_pass++;
        cr_pct = 100;
        step();
        cr_pct = 0;
        n_checks++; if (ar_valid !== 1'b1) $display("FAIL starve_16cr_valid: got %b want 1", ar_valid); else n_pass++;
        step();
        n_checks++; if (ar_addr_q.size() !== 33) $display("FAIL starve_33rd: got %0d want 33", ar_addr_q.size()); else n_pass++;
        cr_pct = 100;
        run_until_done(5000, ok);
        n_checks++; if (ok !== 1'b1 || n_wr !== 1024) $display("FAIL starve_finish: got done=%0d wr=%0d want 1/1024", ok, n_wr); else n_pass++;
        n_checks++; if (n_valid_dev + n_ar_dev + n_dp_dev + n_ctl_dev + n_err_seen !== 0) $display("FAIL starve_model: dev valid=%0d ar=%0d dp=%0d ctl=%0d err=%0d want all 0", n_valid_dev, n_ar_dev, n_dp_dev, n_ctl_dev, n_err_seen); else n_pass++;
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [27:0] a0;
        logic [7:0]  l0;
        do_reset();
        set_knobs(0, 0, 100, 0);
        start_frame(28'h2000, 64);
        a0 = ar_addr; l0 = ar_len;
        n_checks++; if (ar_valid !== 1'b1 || a0 !== 28'h2000 || l0 !== 8'd15) $display("FAIL simul_first: got v=%b %h/%0d want 1 2000/15", ar_valid, a0, l0); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (ar_valid !== 1'b1 || ar_addr !== a0 || ar_len !== l0) $display("FAIL simul_stable%0d: got v=%b %h/%0d want 1 %h/%0d", i, ar_valid, ar_addr, ar_len, a0, l0); else n_pass++;
        end
        set_knobs(100, 0, 100, 100);
        step();
        set_knobs(0, 0, 100, 0);
        n_checks++; if (dut.u_credit.r_credits !== 10'd497) $display("FAIL simul_credit: got %0d want 497", dut.u_credit.r_credits); else n_pass++;
        set_knobs(100, 100, 100, 50);
        run_until_done(2000, ok);
        $display("simul frame base=2000 beats=64 ars=%0d writes=%0d", ar_addr_q.size(), n_wr);
        n_checks++; if (ok !== 1'b1 || n_wr !== 64 || n_ar_dev + n_valid_dev + n_ctl_dev !== 0) $display("FAIL simul_finish: got done=%0d wr=%0d dev=%0d want 1/64/0", ok, n_wr, n_ar_dev + n_valid_dev + n_ctl_dev); else n_pass++;
    endtask

    task automatic test_outstanding();
        bit ok;
        do_reset();
        set_knobs(100, 0, 100, 0);
        start_frame(28'h40000, 200);
        repeat (30) step();
        n_checks++; if (ar_addr_q.size() !== 4 || ar_valid !== 1'b0) $display("FAIL outst_limit: got ars=%0d valid=%b want 4/0", ar_addr_q.size(), ar_valid); else n_pass++;
        set_knobs(100, 100, 0, 0);
        repeat (10) step();
        n_checks++; if (n_wr !== 0 || r_ready !== 1'b0) $display("FAIL backpressure: got wr=%0d r_ready=%b want 0/0", n_wr, r_ready); else n_pass++;
        set_knobs(100, 100, 100, 100);
        run_until_done(3000, ok);
        $display("outst frame base=40000 beats=200 ars=%0d writes=%0d", ar_addr_q.size(), n_wr);
        n_checks++; if (ok !== 1'b1 || n_wr !== 200 || ar_addr_q.size() !== 13) $display("FAIL outst_finish: got done=%0d wr=%0d ars=%0d want 1/200/13", ok, n_wr, ar_addr_q.size()); else n_pass++;
        n_checks++; if (n_valid_dev + n_ar_dev + n_dp_dev + n_ctl_dev + n_err_seen !== 0) $display("FAIL outst_model: dev valid=%0d ar=%0d dp=%0d ctl=%0d err=%0d want all 0", n_valid_dev, n_ar_dev, n_dp_dev, n_ctl_dev, n_err_seen); else n_pass++;
    endtask

    task automatic test_edge_frames();
        bit ok;
        do_reset();
        set_knobs(80, 80, 90, 80);
        start_frame(28'h8000, 0);
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || ar_addr_q.size() !== 0) $display("FAIL zero_beats: got done=%b busy=%b ars=%0d want 1/0/0", done, busy, ar_addr_q.size()); else n_pass++;
        step();
        n_checks++; if (done !== 1'b0) $display("FAIL zero_pulse: got %b want 0", done); else n_pass++;
        clear_obs();
        start_frame(28'hA000, 32);
        for (int i = 0; i < 3; i++) begin
            frame_start = 1'b1; frame_base = 28'hF000; frame_beats = 20'd77;
            step();
        end
        frame_start = 1'b0;
        run_until_done(2000, ok);
        $display("edge frame base=A000 beats=32 ars=%0d writes=%0d", ar_addr_q.size(), n_wr);
        n_checks++; if (ok !== 1'b1 || ar_addr_q.size() !== 2 || n_wr !== 32) $display("FAIL busy_ignore: got done=%0d ars=%0d wr=%0d want 1/2/32", ok, ar_addr_q.size(), n_wr); else n_pass++;
        n_checks++; if (n_valid_dev + n_ar_dev + n_dp_dev + n_ctl_dev + n_err_seen !== 0) $display("FAIL edge_model: dev valid=%0d ar=%0d dp=%0d ctl=%0d err=%0d want all 0", n_valid_dev, n_ar_dev, n_dp_dev, n_ctl_dev, n_err_seen); else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        bit reached;
        do_reset();
        set_knobs(100, 20, 100, 100);
        start_frame(28'h3000, 48);
        reached = 0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            step();
            if (m_busy && m_idx == m_n_ar && m_rcv_left > 0) reached = 1;
        end
        n_checks++; if (reached !== 1'b1 || busy !== 1'b1) $display("FAIL drain_reach: got reached=%0d busy=%b want 1/1", reached, busy); else n_pass++;
        r_valid = 1'b0; r_last = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if ({busy, done, ar_valid, buf_wr_en, err} !== 5'b0 || ar_addr !== 28'h0 || ar_len !== 8'h0) $display("FAIL drain_rst_outs: got %b addr=%h len=%0d want 00000/0/0", {busy, done, ar_valid, buf_wr_en, err}, ar_addr, ar_len); else n_pass++;
        n_checks++; if (dut.u_credit.r_credits !== 10'd512) $display("FAIL drain_rst_credits: got %0d want 512", dut.u_credit.r_credits); else n_pass++;
        do_reset();
    endtask

    task automatic test_err();
        do_reset();
        set_knobs(100, 100, 100, 100);
        early_last_at = 9;
        start_frame(28'h0, 16);
        repeat (20) step();
        early_last_at = -1;
`ifdef RD_BUF_SCHED_ERR_CHK_EN
        n_checks++; if (err !== 1'b1) $display("FAIL err_early_last: got %b want 1", err); else n_pass++;
        r_pct = 0;
        repeat (5) step();
        n_checks++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else n_pass++;
`else
        n_checks++; if (err !== 1'b0) $display("FAIL err_tied: got %b want 0", err); else n_pass++;
`endif
        do_reset();
        n_checks++; if (err !== 1'b0) $display("FAIL err_cleared: got %b want 0", err); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; frame_start = 0; frame_base = '0; frame_beats = '0;
        ar_ready = 0; r_valid = 0; r_last = 0; r_data = '0; buf_wr_rdy = 0; credit_ret = 0;
        set_knobs(0, 0, 0, 0);
        reset_model();
        test_reset();
        test_basic_split();
        test_random_frames();
        test_credit_starvation();
        test_simultaneous();
        test_outstanding();
        test_edge_frames();
        test_reset_mid_drain();
        test_err();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
